// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with write FIFO, runtime frame format and break generator.
//   clk, reset_n       : clock, asynchronous active-low reset
//   divisor            : clock cycles per bit (0 behaves as 1)
//   data_len           : data bits per frame, clamped to 5..MAX_DATA_BITS
//   parity_en/even     : parity enable / even(1) or odd(0)
//   stop2              : two stop bits when set
//   tx_break           : hold line low once the current frame ends
//   wr_valid/ready/data: FIFO write handshake, data sent LSB first
//   fifo_count         : FIFO occupancy
//   busy, done         : frame/break in progress, end-of-frame pulse
//   UART_TX            : serial line, idles high
module uart_tx_fifo #(
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DIV_WIDTH-1:0]         divisor,
    input  logic [3:0]                   data_len,
    input  logic                         parity_en,
    input  logic                         parity_even,
    input  logic                         stop2,
    input  logic                         tx_break,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [MAX_DATA_BITS-1:0]     wr_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         done,
    output logic                         UART_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(MAX_DATA_BITS + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]            count_q, count_d;
    logic [2:0]               state_q, state_d;
    logic [DIV_WIDTH-1:0]     bc_q, bc_d, div_q, div_d, div_c;
    logic [IW-1:0]            idx_q, idx_d, len_q, len_d, len_c;
    logic [MAX_DATA_BITS-1:0] sh_q, sh_d, rd_word;
    logic                     par_q, par_d, pen_q, pen_d, stop2_q, stop2_d;
    logic                     sidx_q, sidx_d, mab_q, mab_d, tx_q, tx_d, done_q, done_d;
    logic                     push, load, wrap, bound, empty, par_c;

    assign rd_word    = mem_q[rp_q];
    assign empty      = count_q == '0;
    assign wr_ready   = count_q != CW'(FIFO_DEPTH);
    assign push       = wr_valid && wr_ready;
    assign wrap       = bc_q == div_q - DIV_WIDTH'(1);
    assign div_c      = divisor == '0 ? DIV_WIDTH'(1) : divisor;
    assign len_c      = data_len < 4'd5 ? IW'(5) :
                        (int'(data_len) > MAX_DATA_BITS ? IW'(MAX_DATA_BITS) : IW'(data_len));
    assign fifo_count = count_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign UART_TX    = tx_q;

    always_comb begin
        par_c = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            par_c = par_c ^ (rd_word[i] & (i < int'(len_c)));
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        len_d   = len_q;
        div_d   = div_q;
        par_d   = par_q;
        pen_d   = pen_q;
        stop2_d = stop2_q;
        sidx_d  = sidx_q;
        mab_d   = mab_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        bound   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = div_c;
                bound = 1'b1;
            end
            START: if (wrap) begin
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
                idx_d   = IW'(1);
                state_d = DATA;
            end
            DATA: if (wrap) begin
                if (idx_q == len_q) begin
                    tx_d    = pen_q ? par_q : 1'b1;
                    state_d = pen_q ? PARITY : STOP;
                end else begin
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + IW'(1);
                end
            end
            PARITY: if (wrap) begin
                tx_d    = 1'b1;
                state_d = STOP;
            end
            STOP: if (wrap) begin
                sidx_d = 1'b1;
                done_d = !(stop2_q && !sidx_q);
                bound  = !(stop2_q && !sidx_q);
            end
            BREAK: begin
                // Mark-after-break starts once tx_break drops, then lasts one bit period.
                mab_d = mab_q || !tx_break;
                tx_d  = mab_q || !tx_break;
                bound = mab_q && wrap;
            end
            default: state_d = IDLE;
        endcase
        // Frame boundary: break wins over queued data, else chain the next frame.
        if (bound) begin
            if (tx_break) begin
                state_d = BREAK;
                tx_d    = 1'b0;
                mab_d   = 1'b0;
            end else if (!empty) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        end
        if (load) begin
            state_d = START;
            tx_d    = 1'b0;
            sh_d    = rd_word;
            div_d   = div_c;
            len_d   = len_c;
            pen_d   = parity_en;
            par_d   = parity_even ? par_c : ~par_c;
            stop2_d = stop2;
            sidx_d  = 1'b0;
        end
    end

    assign bc_d    = (load || state_q == IDLE || (state_q == BREAK && !mab_q) || wrap) ? '0 : bc_q + DIV_WIDTH'(1);
    assign wp_d    = push ? wp_q + AW'(1) : wp_q;
    assign rp_d    = load ? rp_q + AW'(1) : rp_q;
    assign count_d = count_q + CW'(push) - CW'(load);

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wp_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            state_q <= IDLE;
            bc_q    <= '0;
            div_q   <= DIV_WIDTH'(1);
            idx_q   <= '0;
            len_q   <= IW'(5);
            sh_q    <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            sidx_q  <= 1'b0;
            mab_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            state_q <= state_d;
            bc_q    <= bc_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            stop2_q <= stop2_d;
            sidx_q  <= sidx_d;
            mab_q   <= mab_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] divisor;
    logic [3:0]  data_len;
    logic        parity_en, parity_even, stop2, tx_break, wr_valid;
    logic [8:0]  wr_data;
    logic        wr_ready, busy, done, UART_TX;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    logic [511:0] got, dn, bz, exp_w, exp_d, exp_b;

    uart_tx_fifo dut (
        .clk(clk), .reset_n(reset_n), .divisor(divisor), .data_len(data_len),
        .parity_en(parity_en), .parity_even(parity_even), .stop2(stop2),
        .tx_break(tx_break), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .fifo_count(fifo_count), .busy(busy), .done(done),
        .UART_TX(UART_TX)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    // Idle-high waveform with frame f (bit 0 = start bit) placed at sample off, dv samples per bit.
    function automatic logic [511:0] wave(input logic [63:0] f, input int nb, input int dv, input int off);
        logic [511:0] w = '1;
        for (int i = 0; i < nb * dv; i++) w[off + i] = f[i / dv];
        return w;
    endfunction

    task automatic cfg(input logic [15:0] dv, input logic [3:0] dl, input logic pe, input logic pev, input logic s2);
        divisor = dv; data_len = dl; parity_en = pe; parity_even = pev; stop2 = s2;
    endtask

    task automatic write1(input logic [8:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // got[i]/dn[i]/bz[i] hold the line/done/busy seen i+1 negedges after the call.
    task automatic sample(input int n);
        got = '1; dn = '0; bz = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got[i] = UART_TX;
            dn[i]  = done;
            bz[i]  = busy;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (UART_TX !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", UART_TX); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", wr_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_frame;
        @(negedge clk);
        cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        write1(9'h0A5);
        sample(43);
        exp_w = wave({1'b1, 8'hA5, 1'b0}, 10, 4, 1);
        exp_d = '0; exp_d[41] = 1'b1;
        exp_b = '0; for (int i = 1; i <= 40; i++) exp_b[i] = 1'b1;
        total++; if (got !== exp_w) begin bad++; $display("FAIL single_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL single_done got=%h want=%h", dn, exp_d); end
        total++; if (bz !== exp_b) begin bad++; $display("FAIL single_busy got=%h want=%h", bz, exp_b); end
    endtask

    task automatic test_parity_stop;
        cfg(16'd3, 4'd7, 1'b1, 1'b1, 1'b1);
        write1(9'h007);
        sample(36);
        exp_w = wave({1'b1, 1'b1, 1'b1, 7'h07, 1'b0}, 11, 3, 1);
        exp_d = '0; exp_d[34] = 1'b1;
        total++; if (got !== exp_w) begin bad++; $display("FAIL even_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL even_done got=%h want=%h", dn, exp_d); end
        cfg(16'd3, 4'd7, 1'b1, 1'b0, 1'b1);
        write1(9'h007);
        sample(36);
        exp_w = wave({1'b1, 1'b1, 1'b0, 7'h07, 1'b0}, 11, 3, 1);
        total++; if (got !== exp_w) begin bad++; $display("FAIL odd_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL odd_done got=%h want=%h", dn, exp_d); end
        cfg(16'd2, 4'd3, 1'b0, 1'b0, 1'b0);
        write1(9'h1F6);
        sample(17);
        exp_w = wave({1'b1, 5'h16, 1'b0}, 7, 2, 1);
        exp_d = '0; exp_d[15] = 1'b1;
        total++; if (got !== exp_w) begin bad++; $display("FAIL clamp5_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL clamp5_done got=%h want=%h", dn, exp_d); end
    endtask

    task automatic test_divisor;
        int n;
        cfg(16'd0, 4'd12, 1'b1, 1'b1, 1'b0);
        write1(9'h1A5);
        sample(15);
        exp_w = wave({1'b1, 1'b1, 9'h1A5, 1'b0}, 12, 1, 1);
        exp_d = '0; exp_d[13] = 1'b1;
        total++; if (got !== exp_w) begin bad++; $display("FAIL div0_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL div0_done got=%h want=%h", dn, exp_d); end
        cfg(16'hFFFF, 4'd5, 1'b0, 1'b0, 1'b0);
        write1(9'h001);
        @(negedge clk);
        total++; if (UART_TX !== 1'b1) begin bad++; $display("FAIL divmax_idle got=%b want=1", UART_TX); end
        @(negedge clk);
        total++; if (UART_TX !== 1'b0) begin bad++; $display("FAIL divmax_start got=%b want=0", UART_TX); end
        n = 1;
        while (n < 70000) begin
            @(negedge clk);
            if (UART_TX !== 1'b0) break;
            n++;
        end
        total++; if (n != 65535) begin bad++; $display("FAIL divmax_len got=%0d want=65535", n); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [8:0] w [5];
        w = '{9'h115, 9'h00A, 9'h01F, 9'h100, 9'h013};
        @(negedge clk);
        cfg(16'd2, 4'd5, 1'b0, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = w[0];
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    @(posedge clk);
                    #1 wr_data = w[i];
                end
                @(posedge clk);
                #1 wr_data = 9'h1FF;
                @(negedge clk);
                total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", fifo_count); end
                total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", wr_ready); end
                @(posedge clk);
                @(posedge clk);
                #1 wr_valid = 1'b0;
                @(negedge clk);
                total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_hold got=%0d want=4", fifo_count); end
            end
            begin
                @(posedge clk);
                sample(74);
            end
        join
        exp_w = '1;
        exp_d = '0;
        for (int j = 0; j < 5; j++) begin
            exp_w = exp_w & wave({1'b1, w[j][4:0], 1'b0}, 7, 2, 1 + 14 * j);
            exp_d[15 + 14 * j] = 1'b1;
        end
        total++; if (got !== exp_w) begin bad++; $display("FAIL b2b_line got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL b2b_done got=%h want=%h", dn, exp_d); end
        total++; if ($countones(dn) != 5) begin bad++; $display("FAIL b2b_pulses got=%0d want=5", $countones(dn)); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d want=0", fifo_count); end
    endtask

    task automatic test_break;
        @(negedge clk);
        cfg(16'd2, 4'd5, 1'b0, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 9'h00B;
        fork
            begin
                @(posedge clk);
                #1 wr_data = 9'h014;
                @(posedge clk);
                #1 wr_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_break = 1'b1;
                repeat (14) @(posedge clk);
                @(negedge clk);
                total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL brk_count got=%0d want=1", fifo_count); end
                total++; if (UART_TX !== 1'b0) begin bad++; $display("FAIL brk_line got=%b want=0", UART_TX); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL brk_busy got=%b want=1", busy); end
                @(posedge clk);
                @(posedge clk);
                #1 tx_break = 1'b0;
            end
            begin
                @(posedge clk);
                sample(40);
            end
        join
        exp_w = wave({1'b1, 5'h0B, 1'b0}, 7, 2, 1) & wave({1'b1, 5'h14, 1'b0}, 7, 2, 23);
        for (int i = 15; i <= 20; i++) exp_w[i] = 1'b0;
        exp_d = '0; exp_d[15] = 1'b1; exp_d[37] = 1'b1;
        total++; if (got !== exp_w) begin bad++; $display("FAIL brk_wave got=%h want=%h", got, exp_w); end
        total++; if (dn !== exp_d) begin bad++; $display("FAIL brk_done got=%h want=%h", dn, exp_d); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL brk_empty got=%0d want=0", fifo_count); end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 9'h0A5;
        @(posedge clk);
        #1 wr_data = 9'h03C;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        total++; if (UART_TX !== 1'b0) begin bad++; $display("FAIL abort_pre_line got=%b want=0", UART_TX); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL abort_pre_count got=%0d want=1", fifo_count); end
        reset_n = 1'b0;
        #1;
        total++; if (UART_TX !== 1'b1) begin bad++; $display("FAIL abort_line got=%b want=1", UART_TX); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", fifo_count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", wr_ready); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL abort_count_rel got=%0d want=0", fifo_count); end
        sample(6);
        total++; if (got !== {512{1'b1}}) begin bad++; $display("FAIL abort_idle got=%h want=all ones", got); end
    endtask

    initial begin
        reset_n     = 1'b0;
        tx_break    = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_single_frame;
        test_parity_stop;
        test_divisor;
        test_back_to_back;
        test_break;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
